datapath_seq: RTL

- Responder side of the control-unit interface for the 8-bit RISC core.
- Owns the T-state sequence counter that feeds `sc` to control, the PC/MAR/IR/MDR registers, the R0–R3 register file, the internal bus mux and the Z/C flags.
- Executes the strobes control issues (`*_en`, `*_latch`, `*_inc`, `alu_en`, bus selectors, `mem_read`/`mem_write`), and returns `pc`, `mar`, `ir`, `flag_zero` and `flag_carry` to control.

---
 rtl/datapath_seq_pkg.sv | 37 +++
 rtl/datapath_seq_if.sv | 36 +++
 rtl/datapath_seq_seq_counter.sv | 31 +++
 rtl/datapath_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/datapath_seq_pkg.sv
// Shared constants for the 8-bit RISC datapath: widths, T-state names,
// source/destination selector encodings and a wrap-around increment helper.
package risc_pkg;

  localparam int DATA_W = 8;
  localparam int SC_W   = 3;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [SC_W-1:0]   tstate_t;

  localparam tstate_t T0 = 3'd0;
  localparam tstate_t T1 = 3'd1;
  localparam tstate_t T2 = 3'd2;
  localparam tstate_t T3 = 3'd3;
  localparam tstate_t T4 = 3'd4;

  localparam logic [2:0] SEL_R0  = 3'd0;
  localparam logic [2:0] SEL_R1  = 3'd1;
  localparam logic [2:0] SEL_R2  = 3'd2;
  localparam logic [2:0] SEL_R3  = 3'd3;
  localparam logic [2:0] SEL_PC  = 3'd4;
  localparam logic [2:0] SEL_MAR = 3'd5;
  localparam logic [2:0] SEL_IR  = 3'd6;
  localparam logic [2:0] SEL_MDR = 3'd7;

  localparam logic [2:0] DST_R0   = 3'd0;
  localparam logic [2:0] DST_R1   = 3'd1;
  localparam logic [2:0] DST_R2   = 3'd2;
  localparam logic [2:0] DST_R3   = 3'd3;
  localparam logic [2:0] DST_NONE = 3'd4;

  // Register increment; overflow simply drops the carry, so 0xFF -> 0x00.
  function automatic word_t inc_wrap(word_t v);
    return v + word_t'(1);
  endfunction

endpackage

// File: rtl/datapath_seq_if.sv
// Control-unit <-> datapath interface. The master side is the control unit
// (plus the memory and ALU it fronts); the slave side is the datapath.
interface datapath_seq_if;
  import risc_pkg::*;

  tstate_t    sc;
  logic       sc_clr;
  logic       pc_en, mar_en, ir_en;
  logic       pc_latch, mar_latch, ir_latch;
  logic       pc_inc, mar_inc, ir_inc;
  logic       alu_en;
  logic [2:0] src1_bus_selector, src2_bus_selector, dest_bus_selector;
  logic       mem_read, mem_write;
  word_t      mem_addr, mem_wdata, mem_rdata;
  logic       mem_ready;
  word_t      alu_a, alu_b, alu_result;
  logic       alu_carry;
  word_t      pc, mar, ir;
  logic       flag_zero, flag_carry;

  modport master (
    input  sc, mem_addr, mem_wdata, alu_a, alu_b, pc, mar, ir, flag_zero, flag_carry,
    output sc_clr, pc_en, mar_en, ir_en, pc_latch, mar_latch, ir_latch,
           pc_inc, mar_inc, ir_inc, alu_en,
           src1_bus_selector, src2_bus_selector, dest_bus_selector,
           mem_read, mem_write, mem_rdata, mem_ready, alu_result, alu_carry
  );

  modport slave (
    output sc, mem_addr, mem_wdata, alu_a, alu_b, pc, mar, ir, flag_zero, flag_carry,
    input  sc_clr, pc_en, mar_en, ir_en, pc_latch, mar_latch, ir_latch,
           pc_inc, mar_inc, ir_inc, alu_en,
           src1_bus_selector, src2_bus_selector, dest_bus_selector,
           mem_read, mem_write, mem_rdata, mem_ready, alu_result, alu_carry
  );
endinterface

// File: rtl/datapath_seq_seq_counter.sv
// T-state sequence counter. Holds while the datapath is stalled; a clear
// request seen during a stall is honoured on the releasing edge only if it
// is still asserted then.
//
// state | meaning
// T0    | first T-state of an instruction (also after clear / wrap)
// T1-T3 | intermediate T-states
// T4    | last T-state (SC_LAST); next unstalled edge returns to T0
module seq_counter
  import risc_pkg::*;
#(
  parameter tstate_t SC_LAST = T4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    clr,
  input  logic    stall,
  output tstate_t sc
);

  // Advance, wrap or clear on every unstalled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc <= T0;
    end else if (!stall) begin
      if (clr || sc == SC_LAST) sc <= T0;
      else                      sc <= sc + tstate_t'(1);
    end
  end

endmodule

// File: rtl/datapath_seq.sv
// Datapath responder for the 8-bit RISC control unit: PC/MAR/IR/MDR,
// R0-R3, internal bus mux, Z/C flags and the T-state counter.
// Build option: DATAPATH_MEM_WAIT_EN enables the mem_ready wait-state
// handshake; without it every memory access completes in one cycle.
module datapath_seq
  import risc_pkg::*;
#(
  parameter tstate_t SC_LAST = T4
) (
  input logic          clk,
  input logic          rst,
  datapath_seq_if.slave dp
);

  word_t pc_q, mar_q, ir_q, mdr_q;
  word_t rf [4];
  logic  fz_q, fc_q;
  word_t src_a, src_b, bus;
  logic  stall, any_drive, upd;

`ifdef DATAPATH_MEM_WAIT_EN
  assign stall = (dp.mem_read | dp.mem_write) & ~dp.mem_ready;
`else
  logic unused_mem;
  assign unused_mem = dp.mem_ready | dp.mem_write;
  assign stall      = 1'b0;
`endif

  // A simultaneous read and write is a read: only MDR reacts to memory
  // here, so the write simply has no datapath-side effect.
  assign upd       = ~stall;
  assign any_drive = dp.alu_en | dp.pc_en | dp.mar_en | dp.ir_en;

  // Operand selection for the ALU (and the default bus source).
  always_comb begin
    src_a = '0;
    src_b = '0;
    case (dp.src1_bus_selector)
      SEL_R0:  src_a = rf[0];
      SEL_R1:  src_a = rf[1];
      SEL_R2:  src_a = rf[2];
      SEL_R3:  src_a = rf[3];
      SEL_PC:  src_a = pc_q;
      SEL_MAR: src_a = mar_q;
      SEL_IR:  src_a = ir_q;
      default: src_a = mdr_q;
    endcase
    case (dp.src2_bus_selector)
      SEL_R0:  src_b = rf[0];
      SEL_R1:  src_b = rf[1];
      SEL_R2:  src_b = rf[2];
      SEL_R3:  src_b = rf[3];
      SEL_PC:  src_b = pc_q;
      SEL_MAR: src_b = mar_q;
      SEL_IR:  src_b = ir_q;
      default: src_b = mdr_q;
    endcase
  end

  // Internal bus: fixed-priority mux, ALU result first.
  always_comb begin
    bus = src_a;
    if      (dp.alu_en) bus = dp.alu_result;
    else if (dp.pc_en)  bus = pc_q;
    else if (dp.mar_en) bus = mar_q;
    else if (dp.ir_en)  bus = ir_q;
  end

  // PC/MAR/IR: latch wins over increment; both see the pre-edge bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      mar_q <= '0;
      ir_q  <= '0;
    end else if (upd) begin
      if      (dp.pc_latch)  pc_q  <= bus;
      else if (dp.pc_inc)    pc_q  <= inc_wrap(pc_q);
      if      (dp.mar_latch) mar_q <= bus;
      else if (dp.mar_inc)   mar_q <= inc_wrap(mar_q);
      if      (dp.ir_latch)  ir_q  <= bus;
      else if (dp.ir_inc)    ir_q  <= inc_wrap(ir_q);
    end
  end

  // Register file write-back from the bus whenever something drives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (upd && any_drive && !dp.dest_bus_selector[2]) begin
      rf[dp.dest_bus_selector[1:0]] <= bus;
    end
  end

  // MDR capture on a completed read, flags on an ALU cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdr_q <= '0;
      fz_q  <= 1'b0;
      fc_q  <= 1'b0;
    end else if (upd) begin
      if (dp.mem_read) mdr_q <= dp.mem_rdata;
      if (dp.alu_en) begin
        fz_q <= (dp.alu_result == '0);
        fc_q <= dp.alu_carry;
      end
    end
  end

  seq_counter #(.SC_LAST(SC_LAST)) u_seq_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (dp.sc_clr),
    .stall (stall),
    .sc    (dp.sc)
  );

  assign dp.alu_a      = src_a;
  assign dp.alu_b      = src_b;
  assign dp.mem_wdata  = bus;
  assign dp.mem_addr   = mar_q;
  assign dp.pc         = pc_q;
  assign dp.mar        = mar_q;
  assign dp.ir         = ir_q;
  assign dp.flag_zero  = fz_q;
  assign dp.flag_carry = fc_q;

endmodule
